vga_fb_bus_ctrl: RTL and testbench

//  Bus-mapped write/read controller for the VGA frame buffer (port A side).

---
 rtl/vga_fb_bus_ctrl_if.sv | 27 ++
 rtl/vga_fb_bus_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_vga_fb_bus_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_bus_ctrl_if.sv
// rtl/vga_fb_bus_ctrl_if.sv - CPU bus and frame-buffer port A signals of the VGA frame-buffer controller
// master = CPU/frame-buffer environment, slave = controller.
interface vga_fb_bus_ctrl_if #(
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 7,
  parameter int PIX_BITS = 1
);
  logic [7:0]               bus_addr;
  logic                     bus_we;
  logic                     bus_oe;
  logic [Y_BITS+X_BITS-1:0] fb_addr;
  logic [PIX_BITS-1:0]      fb_wdata;
  logic                     fb_we;
  logic [PIX_BITS-1:0]      fb_rdata;
  logic [15:0]              config_colors;
  logic                     busy;

  modport master (
    output bus_addr, bus_we, fb_rdata,
    input  bus_oe, fb_addr, fb_wdata, fb_we, config_colors, busy
  );

  modport slave (
    input  bus_addr, bus_we, fb_rdata,
    output bus_oe, fb_addr, fb_wdata, fb_we, config_colors, busy
  );
endinterface

// File: rtl/vga_fb_bus_ctrl.sv
// rtl/vga_fb_bus_ctrl.sv - bus-mapped pixel write/read controller with fill engine for frame-buffer port A
// Decodes an 8-register window into coordinates, pixel data, colour and control; all outputs registered.
module vga_fb_bus_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int H_PIX    = 160,
  parameter int V_PIX    = 120,
  parameter int X_BITS   = 8,
  parameter int Y_BITS   = 7,
  parameter int PIX_BITS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [7:0]            bus_data,
  vga_fb_bus_ctrl_if.slave      bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_PIX - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_PIX - 1);

  state_t                   state_q, state_d;
  logic [X_BITS-1:0]        x_q, x_d, fx_q, fx_d, ex;
  logic [Y_BITS-1:0]        y_q, y_d, fy_q, fy_d, ey;
  logic [PIX_BITS-1:0]      pix_q, pix_d, fb_wdata_q, fb_wdata_d;
  logic [7:0]               colour_q, colour_d, rd_data_q, rd_data_d;
  logic                     autoinc_q, autoinc_d, yflip_q, yflip_d, oor_q, oor_d;
  logic                     fb_we_q, fb_we_d, busy_q, busy_d, rd_en_q, rd_en_d;
  logic [Y_BITS+X_BITS-1:0] fb_addr_q, fb_addr_d;
  logic [15:0]              config_colors_q, config_colors_d;
  logic [7:0]               off;
  logic                     in_win, wr, rd, filling, stat_rd, fill_start, abort, in_range, emit;

  function automatic logic [Y_BITS-1:0] yphys(input logic [Y_BITS-1:0] y, input logic flip);
    return flip ? (Y_LAST - y) : y;
  endfunction

  assign off        = bus.bus_addr - BASE_ADDR;
  assign in_win     = (off < 8'd8);
  assign wr         = in_win & bus.bus_we;
  assign rd         = in_win & ~bus.bus_we;
  assign filling    = (state_q == ST_FILL);
  assign stat_rd    = rd && (off[2:0] == 3'd5);
  assign abort      = wr && (off[2:0] == 3'd4) && bus_data[3];
  assign fill_start = wr && (off[2:0] == 3'd4) && (state_q == ST_IDLE) && bus_data[2] && !bus_data[3];
  assign in_range   = (x_q <= X_LAST) && (y_q <= Y_LAST);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    pix_d      = pix_q;
    colour_d   = colour_q;
    autoinc_d  = autoinc_q;
    yflip_d    = yflip_q;
    oor_d      = oor_q & ~stat_rd;
    // Idle address follows X/Y so a +2 read sees FB_RDATA for the current coordinates.
    fb_addr_d  = {yphys(y_q, yflip_q), x_q};
    fb_wdata_d = fb_wdata_q;
    fb_we_d    = 1'b0;
    busy_d     = 1'b0;
    emit       = 1'b0;
    ex         = '0;
    ey         = '0;
    rd_en_d    = rd;
    rd_data_d  = '0;

    if (rd) begin
      case (off[2:0])
        3'd0:    rd_data_d = 8'(x_q);
        3'd1:    rd_data_d = 8'(y_q);
        3'd2:    rd_data_d = filling ? 8'd0 : 8'(bus.fb_rdata);
        3'd3:    rd_data_d = colour_q;
        3'd4:    rd_data_d = {6'd0, yflip_q, autoinc_q};
        3'd5:    rd_data_d = {6'd0, oor_q, busy_q};
        default: rd_data_d = '0;
      endcase
    end

    if (wr && !filling) begin
      case (off[2:0])
        3'd0: x_d = bus_data[X_BITS-1:0];
        3'd1: y_d = bus_data[Y_BITS-1:0];
        3'd2: begin
          pix_d      = bus_data[PIX_BITS-1:0];
          fb_wdata_d = bus_data[PIX_BITS-1:0];
          if (in_range) fb_we_d = 1'b1;
          else          oor_d   = 1'b1;
          if (autoinc_q) begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        3'd3: colour_d = bus_data;
        3'd4: begin
          autoinc_d = bus_data[0];
          yflip_d   = bus_data[1];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: if (fill_start) begin
        state_d = ST_FILL;
        emit    = 1'b1;
      end
      ST_FILL: if (abort) begin
        state_d = ST_IDLE;
      end else begin
        emit = 1'b1;
        ex   = fx_q;
        ey   = fy_q;
        if (fx_q == X_LAST && fy_q == Y_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Fill counter holds the next pixel; the start cycle already emits pixel (0,0).
    if (emit) begin
      fb_we_d    = 1'b1;
      busy_d     = 1'b1;
      fb_addr_d  = {yphys(ey, yflip_d), ex};
      fb_wdata_d = pix_q;
      if (ex == X_LAST) begin
        fx_d = '0;
        fy_d = ey + 1'b1;
      end else begin
        fx_d = ex + 1'b1;
        fy_d = ey;
      end
    end

    config_colors_d = {colour_d, ~colour_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      x_q             <= '0;
      y_q             <= '0;
      fx_q            <= '0;
      fy_q            <= '0;
      pix_q           <= '0;
      colour_q        <= 8'h00;
      autoinc_q       <= 1'b0;
      yflip_q         <= 1'b1;
      oor_q           <= 1'b0;
      fb_addr_q       <= '0;
      fb_wdata_q      <= '0;
      fb_we_q         <= 1'b0;
      busy_q          <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_data_q       <= '0;
      config_colors_q <= 16'h00FF;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      fx_q            <= fx_d;
      fy_q            <= fy_d;
      pix_q           <= pix_d;
      colour_q        <= colour_d;
      autoinc_q       <= autoinc_d;
      yflip_q         <= yflip_d;
      oor_q           <= oor_d;
      fb_addr_q       <= fb_addr_d;
      fb_wdata_q      <= fb_wdata_d;
      fb_we_q         <= fb_we_d;
      busy_q          <= busy_d;
      rd_en_q         <= rd_en_d;
      rd_data_q       <= rd_data_d;
      config_colors_q <= config_colors_d;
    end
  end

  assign bus_data          = rd_en_q ? rd_data_q : 8'hzz;
  assign bus.bus_oe        = rd_en_q;
  assign bus.fb_addr       = fb_addr_q;
  assign bus.fb_wdata      = fb_wdata_q;
  assign bus.fb_we         = fb_we_q;
  assign bus.busy          = busy_q;
  assign bus.config_colors = config_colors_q;
endmodule

// File: tb/tb_vga_fb_bus_ctrl.sv
// tb/tb_vga_fb_bus_ctrl.sv - randomized bench for vga_fb_bus_ctrl against a register/frame model
// Frame buffer is modelled as a 1-cycle-latency memory; expectations come from a coordinate-level model.
module tb_vga_fb_bus_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  wire  [7:0] bus_data;

  vga_fb_bus_ctrl_if ifc ();

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  vga_fb_bus_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus_data (bus_data),
    .bus      (ifc)
  );

  bit fb_mem [0:32767];
  always @(posedge clk) begin
    if (ifc.fb_we) fb_mem[ifc.fb_addr] <= ifc.fb_wdata[0];
    ifc.fb_rdata <= fb_mem[ifc.fb_addr];
  end

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  // reference model state
  logic [7:0]  mx, mcol;
  logic [6:0]  my;
  bit          mpix, mauto, mflip, moor, done_cyc;
  int          fill_idx;
  bit          ref_mem [0:32767];
  // expected outputs for the current cycle (e_) and the next one (n_)
  bit          e_we, e_busy, e_oe, n_we, n_busy, n_oe;
  bit          e_wdata, n_wdata;
  logic [14:0] e_addr, n_addr;
  logic [7:0]  e_rd, n_rd;
  logic [15:0] e_col, n_col;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] yp(input logic [6:0] y, input bit f);
    return f ? 7'(7'd119 - y) : y;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mpix = 0; mcol = 0; mauto = 0; mflip = 1; moor = 0;
    fill_idx = -1; done_cyc = 0;
    e_we = 0; e_busy = 0; e_oe = 0; e_col = 16'h00FF; e_addr = 0; e_wdata = 0; e_rd = 0;
  endtask

  task automatic model_step(input logic [7:0] a, input bit we, input logic [7:0] d);
    logic [7:0] off;
    bit inw, emit, was_done;
    int px, py;
    off = a - 8'hB0;
    inw = off < 8;
    n_we = 0; n_busy = 0; n_addr = e_addr; n_wdata = e_wdata;
    n_oe = inw && !we; n_rd = 0; emit = 0;
    was_done = done_cyc; done_cyc = 0;
    if (inw && !we) begin
      case (off)
        0: n_rd = mx;
        1: n_rd = {1'b0, my};
        2: n_rd = (fill_idx >= 0) ? 8'd0 : {7'd0, ref_mem[{yp(my, mflip), mx}]};
        3: n_rd = mcol;
        4: n_rd = {6'd0, mflip, mauto};
        5: begin n_rd = {6'd0, moor, e_busy}; moor = 0; end
        default: n_rd = 0;
      endcase
    end
    if (fill_idx >= 0) begin
      if (inw && we && off == 4 && d[3]) fill_idx = -1;
      else emit = 1;
    end else if (inw && we) begin
      case (off)
        0: mx = d;
        1: my = d[6:0];
        2: begin
          mpix = d[0];
          if (mx < 160 && my < 120) begin
            n_we = 1; n_addr = {yp(my, mflip), mx}; n_wdata = d[0];
            ref_mem[n_addr] = d[0];
          end else moor = 1;
          if (mauto) begin
            if (mx == 159) begin mx = 0; my = (my == 119) ? 7'd0 : 7'(my + 1); end
            else mx = mx + 1;
          end
        end
        3: mcol = d;
        4: begin
          mauto = d[0]; mflip = d[1];
          if (d[2] && !d[3] && !was_done) begin fill_idx = 0; emit = 1; end
        end
        default: ;
      endcase
    end
    if (emit) begin
      px = fill_idx % 160;
      py = fill_idx / 160;
      n_we = 1; n_busy = 1;
      n_addr = {yp(7'(py), mflip), 8'(px)};
      n_wdata = mpix;
      ref_mem[n_addr] = mpix;
      fill_idx++;
      if (fill_idx == 19200) begin fill_idx = -1; done_cyc = 1; end
    end
    n_col = {mcol, ~mcol};
  endtask

  task automatic cycle(input logic [7:0] a, input bit we, input logic [7:0] d);
    ifc.bus_addr = a; ifc.bus_we = we; tb_drv = we; tb_wdata = d;
    model_step(a, we, d);
    @(posedge clk); #1;
    e_we = n_we; e_busy = n_busy; e_oe = n_oe; e_addr = n_addr;
    e_wdata = n_wdata; e_rd = n_rd; e_col = n_col;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cycle(a, 1, d);
    idle(2);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    cycle(a, 0, 8'h00);
    v = bus_data;
    idle(2);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("fb_we", ifc.fb_we, e_we);
      if (e_we) begin
        chk("fb_addr", ifc.fb_addr, e_addr);
        chk("fb_wdata", ifc.fb_wdata, e_wdata);
      end
      chk("busy", ifc.busy, e_busy);
      chk("config_colors", ifc.config_colors, e_col);
      chk("bus_oe", ifc.bus_oe, e_oe);
      if (e_oe) chk("bus_rdata", bus_data, e_rd);
    end
  end

  initial begin
    logic [7:0]  v;
    logic [14:0] last;
    int busy_cnt, we_cnt;
    reset = 1; tb_drv = 0; tb_wdata = 0; ifc.bus_addr = 0; ifc.bus_we = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1; reset = 0; chk_en = 1;

    chk("rst_colors", ifc.config_colors, 16'h00FF);
    chk("rst_fb_we", ifc.fb_we, 0);
    chk("rst_bus_oe", ifc.bus_oe, 0);
    rd(8'hB4, v); chk("rst_ctrl", v, 8'h02);

    wr(8'hB4, 8'h02); wr(8'hB0, 8'd5); wr(8'hB1, 8'd0);
    cycle(8'hB2, 1, 8'h01);
    chk("px_we", ifc.fb_we, 1);
    chk("px_addr", ifc.fb_addr, {7'd119, 8'd5});
    chk("px_wdata", ifc.fb_wdata, 1);
    idle(1);
    chk("px_once", ifc.fb_we, 0);
    idle(1);

    wr(8'hB4, 8'h03); wr(8'hB0, 8'd159); wr(8'hB1, 8'd119);
    cycle(8'hB2, 1, 8'h00);
    chk("wrap_addr", ifc.fb_addr, {7'd0, 8'd159});
    idle(2);
    rd(8'hB0, v); chk("wrap_x", v, 8'd0);
    rd(8'hB1, v); chk("wrap_y", v, 8'd0);

    wr(8'hB0, 8'd160);
    cycle(8'hB2, 1, 8'h01);
    chk("oor_no_we", ifc.fb_we, 0);
    idle(2);
    rd(8'hB5, v); chk("oor_status1", v, 8'h02);
    rd(8'hB5, v); chk("oor_status2", v, 8'h00);

    wr(8'hB4, 8'h02); wr(8'hB0, 8'd0); wr(8'hB1, 8'd0); wr(8'hB2, 8'h01);
    cycle(8'hB4, 1, 8'h06);
    busy_cnt = 0; we_cnt = 0; last = 0;
    for (int i = 0; i < 19300; i++) begin
      if (ifc.busy) busy_cnt++;
      if (ifc.fb_we) begin we_cnt++; last = ifc.fb_addr; end
      idle(1);
    end
    chk("fill_busy_cycles", busy_cnt, 19200);
    chk("fill_writes", we_cnt, 19200);
    chk("fill_last_addr", last, {7'd0, 8'd159});
    rd(8'hB2, v); chk("fill_readback", v, 8'h01);

    cycle(8'hB4, 1, 8'h06);
    we_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      if (ifc.fb_we) we_cnt++;
      if (k == 5)       cycle(8'hB0, 1, 8'h33);
      else if (k == 10) cycle(8'hB4, 1, 8'h08);
      else              idle(1);
    end
    chk("abort_writes", (we_cnt == 10 || we_cnt == 11), 1);
    chk("abort_busy", ifc.busy, 0);
    rd(8'hB0, v); chk("fill_x_kept", v, 8'd0);

    cycle(8'hB4, 1, 8'h0C);
    idle(1);
    chk("start_abort_busy", ifc.busy, 0);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: wr(8'hB0, 8'($urandom_range(150, 170)));
        1: wr(8'hB1, 8'($urandom_range(110, 127)));
        2: wr(8'hB2, 8'($urandom_range(0, 255)));
        3: wr(8'hB3, 8'($urandom_range(0, 255)));
        4: wr(8'hB4, 8'($urandom_range(0, 3)));
        5: rd(8'(8'hB0 + $urandom_range(0, 7)), v);
        6: rd(8'($urandom_range(0, 8'hAF)), v);
        default: wr(($urandom_range(0, 1) != 0) ? 8'hB6 : 8'h10, 8'($urandom_range(0, 255)));
      endcase
    end

    wr(8'hB4, 8'h02);
    cycle(8'hB4, 1, 8'h06);
    idle(50);
    chk_en = 0; reset = 1;
    idle(1);
    reset = 0; model_reset(); chk_en = 1;
    chk("midfill_rst_busy", ifc.busy, 0);
    chk("midfill_rst_colors", ifc.config_colors, 16'h00FF);
    rd(8'hB4, v); chk("midfill_rst_ctrl", v, 8'h02);
    idle(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
